// File: rtl/baccarat_datapath_if.sv
// Hand datapath bus: card/strobe/light inputs from the round FSM side,
// registered cards, scores, tallies and error flags back out.
interface baccarat_datapath_if #(
  parameter int TALLY_W = 8
);
  logic [3:0]         dealt_card;
  logic               load_pcard1;
  logic               load_pcard2;
  logic               load_pcard3;
  logic               load_dcard1;
  logic               load_dcard2;
  logic               load_dcard3;
  logic               player_win_light;
  logic               dealer_win_light;

  logic [3:0]         pcard1;
  logic [3:0]         pcard2;
  logic [3:0]         pcard3;
  logic [3:0]         dcard1;
  logic [3:0]         dcard2;
  logic [3:0]         dcard3;
  logic [3:0]         pscore;
  logic [3:0]         dscore;
  logic [TALLY_W-1:0] player_wins;
  logic [TALLY_W-1:0] dealer_wins;
  logic [TALLY_W-1:0] ties;
  logic               bad_card;
  logic               multi_load_err;

  modport master (
    output dealt_card, load_pcard1, load_pcard2, load_pcard3,
           load_dcard1, load_dcard2, load_dcard3,
           player_win_light, dealer_win_light,
    input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
           pscore, dscore, player_wins, dealer_wins, ties,
           bad_card, multi_load_err
  );

  modport slave (
    input  dealt_card, load_pcard1, load_pcard2, load_pcard3,
           load_dcard1, load_dcard2, load_dcard3,
           player_win_light, dealer_win_light,
    output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
           pscore, dscore, player_wins, dealer_wins, ties,
           bad_card, multi_load_err
  );
endinterface

// File: rtl/baccarat_datapath.sv
// Baccarat hand datapath: latches dealt cards, produces combinational hand
// scores for the round FSM, and keeps saturating win/loss/tie tallies.
module baccarat_datapath #(
  parameter int TALLY_W  = 8,
  parameter int MAX_CARD = 13
) (
  input  logic slow_clock,
  input  logic resetb,
  baccarat_datapath_if.slave bus
);

  localparam logic [3:0]         MAX_CODE  = MAX_CARD[3:0];
  localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

  logic [3:0]         r_pcard1, r_pcard2, r_pcard3;
  logic [3:0]         r_dcard1, r_dcard2, r_dcard3;
  logic [TALLY_W-1:0] r_player_wins, r_dealer_wins, r_ties;
  logic               r_bad_card;
  logic               r_multi_load_err;
  logic               r_prev_light;

  logic [5:0] w_loads;
  logic       w_any_load;
  logic       w_multi_load;
  logic       w_single_load;
  logic       w_card_ok;
  logic [3:0] w_card_val;
  logic       w_light;
  logic       w_light_rise;

  // Bit order: {p1, p2, p3, d1, d2, d3}
  assign w_loads = {bus.load_pcard1, bus.load_pcard2, bus.load_pcard3,
                    bus.load_dcard1, bus.load_dcard2, bus.load_dcard3};
  assign w_any_load    = |w_loads;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign w_multi_load  = |(w_loads & (w_loads - 6'd1));
  assign w_single_load = w_any_load & ~w_multi_load;

  assign w_card_ok  = (bus.dealt_card != 4'd0) && (bus.dealt_card <= MAX_CODE);
  assign w_card_val = w_card_ok ? bus.dealt_card : 4'd0;

  assign w_light      = bus.player_win_light | bus.dealer_win_light;
  assign w_light_rise = w_light & ~r_prev_light;

  // Face value for scoring: 1..9 count as-is, empty and 10/J/Q/K count zero.
  function automatic logic [4:0] card_points(input logic [3:0] card);
    return ((card >= 4'd1) && (card <= 4'd9)) ? {1'b0, card} : 5'd0;
  endfunction

  // Sum of three cards is at most 27, so two conditional subtracts give mod 10.
  function automatic logic [3:0] hand_score(input logic [3:0] c1,
                                            input logic [3:0] c2,
                                            input logic [3:0] c3);
    logic [4:0] sum;
    logic [4:0] red;
    sum = card_points(c1) + card_points(c2) + card_points(c3);
    if (sum >= 5'd20)      red = sum - 5'd20;
    else if (sum >= 5'd10) red = sum - 5'd10;
    else                   red = sum;
    return red[3:0];
  endfunction

  // Card registers: single strobe loads one card; pcard1 also starts a new round.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_pcard1 <= 4'd0;
      r_pcard2 <= 4'd0;
      r_pcard3 <= 4'd0;
      r_dcard1 <= 4'd0;
      r_dcard2 <= 4'd0;
      r_dcard3 <= 4'd0;
    end else if (w_single_load) begin
      unique case (w_loads)
        6'b100000: begin
          r_pcard1 <= w_card_val;
          r_pcard2 <= 4'd0;
          r_pcard3 <= 4'd0;
          r_dcard1 <= 4'd0;
          r_dcard2 <= 4'd0;
          r_dcard3 <= 4'd0;
        end
        6'b010000: r_pcard2 <= w_card_val;
        6'b001000: r_pcard3 <= w_card_val;
        6'b000100: r_dcard1 <= w_card_val;
        6'b000010: r_dcard2 <= w_card_val;
        6'b000001: r_dcard3 <= w_card_val;
        default: ;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_bad_card       <= 1'b0;
      r_multi_load_err <= 1'b0;
    end else begin
      if (w_single_load && !w_card_ok) r_bad_card <= 1'b1;
      if (w_multi_load)                r_multi_load_err <= 1'b1;
    end
  end

  // Light edge detector and saturating result tallies, one count per round.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_prev_light  <= 1'b0;
      r_player_wins <= '0;
      r_dealer_wins <= '0;
      r_ties        <= '0;
    end else begin
      r_prev_light <= w_light;
      if (w_light_rise) begin
        if (bus.player_win_light && bus.dealer_win_light) begin
          if (r_ties != TALLY_MAX) r_ties <= r_ties + 1'b1;
        end else if (bus.player_win_light) begin
          if (r_player_wins != TALLY_MAX) r_player_wins <= r_player_wins + 1'b1;
        end else begin
          if (r_dealer_wins != TALLY_MAX) r_dealer_wins <= r_dealer_wins + 1'b1;
        end
      end
    end
  end

  assign bus.pcard1         = r_pcard1;
  assign bus.pcard2         = r_pcard2;
  assign bus.pcard3         = r_pcard3;
  assign bus.dcard1         = r_dcard1;
  assign bus.dcard2         = r_dcard2;
  assign bus.dcard3         = r_dcard3;
  // Scores are combinational so the FSM sees them on the following falling edge.
  assign bus.pscore         = hand_score(r_pcard1, r_pcard2, r_pcard3);
  assign bus.dscore         = hand_score(r_dcard1, r_dcard2, r_dcard3);
  assign bus.player_wins    = r_player_wins;
  assign bus.dealer_wins    = r_dealer_wins;
  assign bus.ties           = r_ties;
  assign bus.bad_card       = r_bad_card;
  assign bus.multi_load_err = r_multi_load_err;

endmodule

// File: tb/tb_baccarat_datapath.sv
// Directed table-driven bench for baccarat_datapath. Two instances share
// stimulus: u_dut_a with 8-bit tallies, u_dut_b with 2-bit tallies for saturation.
module tb_baccarat_datapath;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic [3:0] dealt_card = 4'd0;
  logic [5:0] loads      = 6'd0;   // {p1, p2, p3, d1, d2, d3}
  logic       plight     = 1'b0;
  logic       dlight     = 1'b0;

  int tests  = 0;
  int failed = 0;

  always #5 slow_clock = ~slow_clock;

  baccarat_datapath_if #(.TALLY_W(8)) ifa ();
  baccarat_datapath_if #(.TALLY_W(2)) ifb ();

  assign ifa.dealt_card       = dealt_card;
  assign ifa.load_pcard1      = loads[5];
  assign ifa.load_pcard2      = loads[4];
  assign ifa.load_pcard3      = loads[3];
  assign ifa.load_dcard1      = loads[2];
  assign ifa.load_dcard2      = loads[1];
  assign ifa.load_dcard3      = loads[0];
  assign ifa.player_win_light = plight;
  assign ifa.dealer_win_light = dlight;

  assign ifb.dealt_card       = dealt_card;
  assign ifb.load_pcard1      = loads[5];
  assign ifb.load_pcard2      = loads[4];
  assign ifb.load_pcard3      = loads[3];
  assign ifb.load_dcard1      = loads[2];
  assign ifb.load_dcard2      = loads[1];
  assign ifb.load_dcard3      = loads[0];
  assign ifb.player_win_light = plight;
  assign ifb.dealer_win_light = dlight;

  baccarat_datapath #(.TALLY_W(8), .MAX_CARD(13)) u_dut_a (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (ifa.slave)
  );

  baccarat_datapath #(.TALLY_W(2), .MAX_CARD(13)) u_dut_b (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (ifb.slave)
  );

  typedef struct {
    logic [5:0] ld;
    logic [3:0] card;
    logic       pl, dl;
    logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds;
    logic [7:0] pw, dw, tw;
    logic       bad, mle;
    logic [1:0] dwb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [5:0] ld, logic [3:0] card, logic pl, logic dl,
                              logic [3:0] p1, logic [3:0] p2, logic [3:0] p3,
                              logic [3:0] d1, logic [3:0] d2, logic [3:0] d3,
                              logic [3:0] ps, logic [3:0] ds,
                              logic [7:0] pw, logic [7:0] dw, logic [7:0] tw,
                              logic bad, logic mle, logic [1:0] dwb);
    vec_t v;
    v.ld = ld; v.card = card; v.pl = pl; v.dl = dl;
    v.p1 = p1; v.p2 = p2; v.p3 = p3; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.ps = ps; v.ds = ds; v.pw = pw; v.dw = dw; v.tw = tw;
    v.bad = bad; v.mle = mle; v.dwb = dwb;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_vec(input int i, input vec_t v);
    chk("pcard1", i, 32'(ifa.pcard1), 32'(v.p1));
    chk("pcard2", i, 32'(ifa.pcard2), 32'(v.p2));
    chk("pcard3", i, 32'(ifa.pcard3), 32'(v.p3));
    chk("dcard1", i, 32'(ifa.dcard1), 32'(v.d1));
    chk("dcard2", i, 32'(ifa.dcard2), 32'(v.d2));
    chk("dcard3", i, 32'(ifa.dcard3), 32'(v.d3));
    chk("pscore", i, 32'(ifa.pscore), 32'(v.ps));
    chk("dscore", i, 32'(ifa.dscore), 32'(v.ds));
    chk("player_wins", i, 32'(ifa.player_wins), 32'(v.pw));
    chk("dealer_wins", i, 32'(ifa.dealer_wins), 32'(v.dw));
    chk("ties", i, 32'(ifa.ties), 32'(v.tw));
    chk("bad_card", i, 32'(ifa.bad_card), 32'(v.bad));
    chk("multi_load_err", i, 32'(ifa.multi_load_err), 32'(v.mle));
    chk("dealer_wins_sat", i, 32'(ifb.dealer_wins), 32'(v.dwb));
  endtask

  task automatic chk_all_zero(input int idx);
    chk("rst pcard1", idx, 32'(ifa.pcard1), 0);
    chk("rst pcard2", idx, 32'(ifa.pcard2), 0);
    chk("rst pcard3", idx, 32'(ifa.pcard3), 0);
    chk("rst dcard1", idx, 32'(ifa.dcard1), 0);
    chk("rst dcard2", idx, 32'(ifa.dcard2), 0);
    chk("rst dcard3", idx, 32'(ifa.dcard3), 0);
    chk("rst pscore", idx, 32'(ifa.pscore), 0);
    chk("rst dscore", idx, 32'(ifa.dscore), 0);
    chk("rst player_wins", idx, 32'(ifa.player_wins), 0);
    chk("rst dealer_wins", idx, 32'(ifa.dealer_wins), 0);
    chk("rst ties", idx, 32'(ifa.ties), 0);
    chk("rst bad_card", idx, 32'(ifa.bad_card), 0);
    chk("rst multi_load_err", idx, 32'(ifa.multi_load_err), 0);
    chk("rst dealer_wins_sat", idx, 32'(ifb.dealer_wins), 0);
  endtask

  initial begin
    //                 ld        card  pl dl   p1 p2 p3  d1 d2 d3  ps ds  pw dw tw bad mle dwb
    vecs.push_back(mk(6'b000000, 4'd0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6'b100000, 4'd7, 0, 0,  7, 0, 0,  0, 0, 0,  7, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6'b000100, 4'd3, 0, 0,  7, 0, 0,  3, 0, 0,  7, 3,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6'b010000, 4'd8, 0, 0,  7, 8, 0,  3, 0, 0,  5, 3,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6'b000010, 4'd13,0, 0,  7, 8, 0,  3,13, 0,  5, 3,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6'b001000, 4'd12,0, 0,  7, 8,12,  3,13, 0,  5, 3,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6'b000001, 4'd9, 0, 0,  7, 8,12,  3,13, 9,  5, 2,  0, 0, 0, 0, 0, 0));
    // player light held three cycles counts once
    vecs.push_back(mk(6'b000000, 4'd0, 1, 0,  7, 8,12,  3,13, 9,  5, 2,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6'b000000, 4'd0, 1, 0,  7, 8,12,  3,13, 9,  5, 2,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6'b000000, 4'd0, 1, 0,  7, 8,12,  3,13, 9,  5, 2,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6'b000000, 4'd0, 0, 0,  7, 8,12,  3,13, 9,  5, 2,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6'b000000, 4'd0, 1, 1,  7, 8,12,  3,13, 9,  5, 2,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(6'b000000, 4'd0, 0, 0,  7, 8,12,  3,13, 9,  5, 2,  1, 0, 1, 0, 0, 0));
    // new round clears the other five cards
    vecs.push_back(mk(6'b100000, 4'd4, 0, 0,  4, 0, 0,  0, 0, 0,  4, 0,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(6'b010100, 4'd5, 0, 0,  4, 0, 0,  0, 0, 0,  4, 0,  1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(6'b000100, 4'd14,0, 0,  4, 0, 0,  0, 0, 0,  4, 0,  1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(6'b000000, 4'd0, 0, 1,  4, 0, 0,  0, 0, 0,  4, 0,  1, 1, 1, 1, 1, 1));
    vecs.push_back(mk(6'b000000, 4'd0, 0, 0,  4, 0, 0,  0, 0, 0,  4, 0,  1, 1, 1, 1, 1, 1));
    // strobe and rising light in the same cycle
    vecs.push_back(mk(6'b000100, 4'd6, 0, 1,  4, 0, 0,  6, 0, 0,  4, 6,  1, 2, 1, 1, 1, 2));
    vecs.push_back(mk(6'b010000, 4'd15,0, 0,  4, 0, 0,  6, 0, 0,  4, 6,  1, 2, 1, 1, 1, 2));
    // more dealer wins: 2-bit tally saturates at 3
    vecs.push_back(mk(6'b000000, 4'd0, 0, 1,  4, 0, 0,  6, 0, 0,  4, 6,  1, 3, 1, 1, 1, 3));
    vecs.push_back(mk(6'b000000, 4'd0, 0, 0,  4, 0, 0,  6, 0, 0,  4, 6,  1, 3, 1, 1, 1, 3));
    vecs.push_back(mk(6'b000000, 4'd0, 0, 1,  4, 0, 0,  6, 0, 0,  4, 6,  1, 4, 1, 1, 1, 3));
    vecs.push_back(mk(6'b000000, 4'd0, 0, 0,  4, 0, 0,  6, 0, 0,  4, 6,  1, 4, 1, 1, 1, 3));
    vecs.push_back(mk(6'b000000, 4'd0, 0, 1,  4, 0, 0,  6, 0, 0,  4, 6,  1, 5, 1, 1, 1, 3));

    // Reset state, checked with the reset still asserted.
    repeat (2) @(negedge slow_clock);
    chk_all_zero(-1);
    resetb = 1'b1;

    foreach (vecs[i]) begin
      @(negedge slow_clock);
      loads      = vecs[i].ld;
      dealt_card = vecs[i].card;
      plight     = vecs[i].pl;
      dlight     = vecs[i].dl;
      @(posedge slow_clock);
      #1;
      chk_vec(i, vecs[i]);
    end

    // Async reset mid-round: outputs clear between clock edges.
    @(negedge slow_clock);
    loads = 6'd0;
    dlight = 1'b1;
    #2;
    resetb = 1'b0;
    #1;
    chk_all_zero(100);

    // Light still high at release counts once, then holds.
    @(negedge slow_clock);
    resetb = 1'b1;
    @(posedge slow_clock);
    #1;
    chk("post-rst dealer_wins", 101, 32'(ifa.dealer_wins), 1);
    chk("post-rst dealer_wins_sat", 101, 32'(ifb.dealer_wins), 1);
    @(posedge slow_clock);
    #1;
    chk("held dealer_wins", 102, 32'(ifa.dealer_wins), 1);
    chk("held ties", 102, 32'(ifa.ties), 0);
    chk("held pcard1", 102, 32'(ifa.pcard1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/baccarat_datapath.md
Name: baccarat_datapath

Overview:
- Hand datapath directly downstream of the baccarat round state machine.
- Consumes the six load strobes and the two win lights; latches dealt cards into six card registers.
- Computes pscore and dscore and feeds them back with pcard3 to the state machine.
- Keeps saturating win/loss/tie tallies across rounds for display.

Parameters:
TALLY_W, 8, width of each win/tie counter.
MAX_CARD, 13, highest legal card code (1=A, 11=J, 12=Q, 13=K).

Ports:
slow_clock  in  1  single clock; all registers update on its rising edge.
resetb  in  1  asynchronous active-low reset.
dealt_card  in  4  card code presented by the card source.
load_pcard1  in  1  load player card 1; also starts a new round.
load_pcard2  in  1  load player card 2.
load_pcard3  in  1  load player card 3.
load_dcard1  in  1  load dealer card 1.
load_dcard2  in  1  load dealer card 2.
load_dcard3  in  1  load dealer card 3.
player_win_light  in  1  win light from state machine.
dealer_win_light  in  1  win light from state machine.
pcard1, pcard2, pcard3  out  4 each  registered player cards; 0 = empty.
dcard1, dcard2, dcard3  out  4 each  registered dealer cards; 0 = empty.
pscore  out  4  player hand score, 0..9.
dscore  out  4  dealer hand score, 0..9.
player_wins  out  TALLY_W  rounds won by player.
dealer_wins  out  TALLY_W  rounds won by dealer.
ties  out  TALLY_W  tied rounds.
bad_card  out  1  sticky: an illegal dealt_card was loaded.
multi_load_err  out  1  sticky: more than one load strobe seen in a cycle.

Behaviour:
- Reset (resetb=0, async): all six card registers, all tallies, bad_card, multi_load_err, and the internal prev_light register go to 0. Therefore pscore=dscore=0.
- Timing: the upstream FSM drives strobes from the falling edge. This block samples them on the rising edge, half a cycle later. Card registers update one rising edge after a strobe asserts.
- Exactly one strobe high:
  - The corresponding card register <= dealt_card, if dealt_card is in 1..MAX_CARD.
  - If dealt_card is 0 or > MAX_CARD, the register <= 0 and bad_card <= 1.
- load_pcard1 (sole strobe) additionally clears pcard2, pcard3, dcard1, dcard2 and dcard3 on the same edge. This is the new-round clear.
- Two or more strobes high in one cycle: no card register changes; multi_load_err <= 1.
- No strobe high: card registers hold.
- Card value for scoring: codes 1..9 score face value; codes 0 and 10..15 score 0.
- Scores:
  - pscore = (val(pcard1) + val(pcard2) + val(pcard3)) mod 10. Use a 5-bit intermediate sum (max 27), then reduce.
  - dscore is computed the same way from the dealer cards.
  - Both are combinational from the card registers, so they are valid in the same cycle the registers change. This gives zero added latency, which the FSM requires because it samples scores on the next falling edge.
- Win detection:
  - prev_light <= player_win_light | dealer_win_light on every rising edge.
  - A round result is recorded only when (player_win_light | dealer_win_light) = 1 and prev_light = 0. One count per round, even if the lights are held for several cycles.
  - Classification: both lights high = ties+1; player only = player_wins+1; dealer only = dealer_wins+1.
- Tallies saturate at 2^TALLY_W-1 and never wrap.
- Sticky flags clear only on reset.
- Reset mid-round: all state is cleared immediately, asynchronously. The first rising edge after resetb deasserts sees prev_light=0, so lights already high at release count once.
- Strobe and rising light edge in the same cycle: both actions take effect independently.

Test Plan:
- Reset, then pulse load_pcard1 (dealt 7), load_dcard1 (3), load_pcard2 (8), load_dcard2 (13), one per cycle -> pcard1=7, pcard2=8, dcard1=3, dcard2=13; pscore=5, dscore=3.
- Continue: load_pcard3 with dealt 12, then load_dcard3 with dealt 9 -> pcard3=12, pscore=5; dcard3=9, dscore=2.
- Hold player_win_light=1 for 3 cycles -> player_wins=1, dealer_wins=0, ties=0. Then both lights high after a low gap -> ties=1.
- Next round: pulse load_pcard1 with dealt 4 -> pcard1=4, all other cards=0, pscore=4, dscore=0.
- load_dcard1 and load_pcard2 asserted together with dealt 5 -> registers unchanged, multi_load_err=1. Then load_dcard1 with dealt 14 -> dcard1=0, bad_card=1.
- With TALLY_W=2, record 5 dealer wins separated by low gaps -> dealer_wins=3 (saturated). Assert resetb=0 mid-sequence -> all outputs 0 without waiting for a clock edge.
